control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Instruction sequencer for the 4-bit datapath. Runs the 8-phase machine cycle (A1 A2 A3 M1 M2 X1 X2 X3):
//  drives the 12-bit PC out on the nibble bus, latches the OPR/OPA opcode nibbles, decodes them, and
//  issues the single-cycle datapath control strobes in X3. Sits between the external ROM bus and the datapath.
// PARAMETERS
//  PC_WIDTH      12      program counter width; fixed at 3 nibbles
//  RESET_VECTOR  12'h000 PC value loaded on reset
// PORTS
//  clock              in   1   system clock
//  reset              in   1   asynchronous, active-low reset
//  halt_req           in   1   freeze sequencer and datapath while high
//  bus_in             in   4   ROM nibble bus (opcode nibbles sampled in M1/M2)
//  bus_out            out  4   address nibble driven in A1/A2/A3
//  bus_oe             out  1   high in A1..A3 only
//  sync               out  1   high in X3; marks the start of the next machine cycle
//  take_branch        in   1   datapath branch-condition result (combinational on inst_operand)
//  halt               out  1   = halt_req; to datapath
//  inst_operand       out  4   OPA of the current instruction (JCN: the condition nibble, held across both words)
//  clear_carry, write_carry, clear_accumulator, write_accumulator, write_register   out 1 each
//  acc_input_sel out 3, reg_input_sel out 2, alu_op out 2, alu_in0_sel out 3, alu_in1_sel out 2, alu_cin_sel out 2
// BEHAVIOUR
//  - Reset (async, low): phase=A1, PC=RESET_VECTOR, opr/opa/cond=0, second_word=0. All outputs 0 during and after reset.
//  - Phase counter: 3 bits; advances once per clock when !halt_req; wraps X3->A1. halt_req freezes phase, PC and latches.
//    All strobes are forced low while halt_req=1.
//  - A1/A2/A3: bus_out = PC[3:0], PC[7:4], PC[11:8]; bus_oe=1. At end of A3, PC <= PC+1 (wraps FFF->000).
//  - M1: opr <= bus_in. M2: opa <= bus_in. In a second-word cycle these are loaded into addr_hi/addr_lo instead.
//  - X1/X2: no strobes. X3: exactly one clock of strobes for the decoded instruction; all strobes 0 in every other phase.
//  - Select outputs are don't-care when their write strobe is 0; drive 0.
//  - Decode (opr,opa); R = opa, register index:
//    0x00 NOP     none
//    0x1C JCN     2 words; first word: cond <= C, second_word <= 1, no strobes.
//                 Second word X3: inst_operand = cond; if take_branch, PC <= {PC[11:8], opr2, opa2}
//    0x4A JUN     2 words; second word X3: PC <= {A, opr2, opa2}
//    0x6R INC R   reg R <= R+1 via ALU (cin=1), carry unchanged
//    0x8R ADD R   acc <= acc+R+carry; carry <= cout
//    0x9R SUB R   acc <= acc+~R+~carry; carry <= cout
//    0xAR LD R    acc <= R
//    0xBR XCH R   reg R <= acc and acc <= R in the same X3
//    0xDN LDM N   acc <= N (acc_input_sel = immediate)
//    0xF0 CLB     clear_accumulator=1, clear_carry=1
//    0xF1 CLC     clear_carry=1
//    0xF2 IAC     acc <= acc+1; carry <= cout
//    0xF7 TCC     acc <= {000,carry}; clear_carry=1 (clear is sequential; acc gets pre-clear carry)
//    anything else: NOP
//  - Register index R > 5: write_register suppressed; acc-side effects still performed.
//  - second_word clears in the X3 of the second word. JCN/JUN across a page end: PC[11:8] is the value after the
//    second-word A3 increment.
//  - Reset mid-cycle or mid two-word instruction: sequence abandoned, restart at A1 of RESET_VECTOR.
// TESTING
//  1. Reset low mid-M2, release -> bus_out 0,0,0 in A1..A3; sync pulses every 8 clocks in X3 only.
//  2. ROM: D5, 82 (carry=0, R2=3) -> acc=5 after LDM; acc=8, carry=0 after ADD; strobes only in X3.
//  3. F2 with acc=F -> acc=0, carry=1; then F7 -> acc=1, carry=0.
//  4. JCN 14,3A at PC 0x010 with acc=0 -> next fetch address 0x03A; with acc=2 -> 0x012.
//  5. JUN 47,89 -> next fetch address 0x789; PC FFF fetch wraps to 000.
//  6. halt_req held 5 clocks in M1 -> phase/PC frozen, all strobes 0, halt=1; resume completes the cycle unchanged.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer
//   Instruction sequencer for the 4-bit datapath. Runs the 8-phase machine
//   cycle A1 A2 A3 M1 M2 X1 X2 X3. It drives the PC out a nibble at a time,
//   latches the OPR/OPA opcode nibbles from the ROM bus, decodes them, and
//   issues one clock of datapath control strobes in X3.
//
// Ports
//   clock, reset (async, active-low)    clock and reset
//   halt_req / halt                     freeze request in / pass-through to datapath
//   bus_in[3:0]                         ROM nibble bus, sampled at the end of M1/M2
//   bus_out[3:0], bus_oe                address nibble out in A1..A3
//   sync                                high in X3
//   take_branch                         datapath branch condition on inst_operand
//   inst_operand[3:0]                   OPA of the current instruction (JCN: condition)
//   clear_carry, write_carry, clear_accumulator, write_accumulator, write_register
//   acc_input_sel  0=ALU 1=register 2=immediate(inst_operand) 3={000,carry}
//   reg_input_sel  0=ALU 1=accumulator
//   alu_op         0=in0+in1+cin     1=in0+~in1+cin
//   alu_in0_sel    0=zero 1=accumulator 2=register
//   alu_in1_sel    0=zero 1=register
//   alu_cin_sel    0=zero 1=one 2=carry 3=~carry
//
// All registered outputs are loaded from the next-state values, so each phase's
// outputs appear in that phase. They are 0 during reset and in the first A1
// after it.
module control_sequencer #(
  parameter int                  PC_WIDTH     = 12,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = 12'h000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       halt_req,
  input  logic [3:0] bus_in,
  output logic [3:0] bus_out,
  output logic       bus_oe,
  output logic       sync,
  input  logic       take_branch,
  output logic       halt,
  output logic [3:0] inst_operand,
  output logic       clear_carry,
  output logic       write_carry,
  output logic       clear_accumulator,
  output logic       write_accumulator,
  output logic       write_register,
  output logic [2:0] acc_input_sel,
  output logic [1:0] reg_input_sel,
  output logic [1:0] alu_op,
  output logic [2:0] alu_in0_sel,
  output logic [1:0] alu_in1_sel,
  output logic [1:0] alu_cin_sel
);

  typedef enum logic [2:0] {
    PH_A1, PH_A2, PH_A3, PH_M1, PH_M2, PH_X1, PH_X2, PH_X3
  } phase_t;

  localparam logic [2:0] ACC_ALU = 3'd0, ACC_REG = 3'd1, ACC_IMM = 3'd2, ACC_CY = 3'd3;
  localparam logic [1:0] REG_ALU = 2'd0, REG_ACC = 2'd1;
  localparam logic [1:0] ALU_ADD = 2'd0, ALU_SUB = 2'd1;
  localparam logic [2:0] IN0_ACC = 3'd1, IN0_REG = 3'd2;
  localparam logic [1:0] IN1_ZERO = 2'd0, IN1_REG = 2'd1;
  localparam logic [1:0] CIN_ONE = 2'd1, CIN_CY = 2'd2, CIN_NCY = 2'd3;

  phase_t              r_phase;
  logic [PC_WIDTH-1:0] r_pc;
  logic [3:0]          r_opr, r_opa, r_cond, r_addr_hi, r_addr_lo;
  logic                r_second_word;

  logic [3:0] r_bus_out;
  logic       r_bus_oe, r_sync;
  logic       r_clr_cy, r_wr_cy, r_clr_acc, r_wr_acc, r_wr_reg;
  logic [2:0] r_acc_sel, r_in0_sel;
  logic [1:0] r_reg_sel, r_alu_op, r_in1_sel, r_cin_sel;

  phase_t              w_phase_next;
  logic [PC_WIDTH-1:0] w_pc_next;
  logic                w_reg_ok;
  logic                w_clr_cy, w_wr_cy, w_clr_acc, w_wr_acc, w_wr_reg;
  logic [2:0]          w_acc_sel, w_in0_sel;
  logic [1:0]          w_reg_sel, w_alu_op, w_in1_sel, w_cin_sel;
  logic                w_run;

  // Next phase and PC; halt_req holds both.
  always_comb begin
    w_phase_next = r_phase;
    w_pc_next    = r_pc;
    if (!halt_req) begin
      w_phase_next = phase_t'(r_phase + 3'd1);
      if (r_phase == PH_A3) begin
        w_pc_next = r_pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
      end else if (r_phase == PH_X3 && r_second_word) begin
        if (r_opr == 4'h4)
          w_pc_next = {r_opa, r_addr_hi, r_addr_lo};
        else if (r_opr == 4'h1 && take_branch)
          w_pc_next = {r_pc[PC_WIDTH-1:8], r_addr_hi, r_addr_lo};
      end
    end
  end

  // Instruction decode for the X3 strobes.
  always_comb begin
    w_reg_ok  = (r_opa <= 4'd5);
    w_clr_cy  = 1'b0;
    w_wr_cy   = 1'b0;
    w_clr_acc = 1'b0;
    w_wr_acc  = 1'b0;
    w_wr_reg  = 1'b0;
    w_acc_sel = '0;
    w_reg_sel = '0;
    w_alu_op  = '0;
    w_in0_sel = '0;
    w_in1_sel = '0;
    w_cin_sel = '0;
    if (!r_second_word) begin
      case (r_opr)
        4'h6: if (w_reg_ok) begin
          w_wr_reg  = 1'b1;
          w_reg_sel = REG_ALU;
          w_alu_op  = ALU_ADD;
          w_in0_sel = IN0_REG;
          w_in1_sel = IN1_ZERO;
          w_cin_sel = CIN_ONE;
        end
        4'h8, 4'h9: begin
          w_wr_acc  = 1'b1;
          w_wr_cy   = 1'b1;
          w_acc_sel = ACC_ALU;
          w_in0_sel = IN0_ACC;
          w_in1_sel = IN1_REG;
          w_alu_op  = (r_opr == 4'h9) ? ALU_SUB : ALU_ADD;
          w_cin_sel = (r_opr == 4'h9) ? CIN_NCY : CIN_CY;
        end
        4'hA: begin
          w_wr_acc  = 1'b1;
          w_acc_sel = ACC_REG;
        end
        4'hB: begin
          w_wr_acc  = 1'b1;
          w_acc_sel = ACC_REG;
          if (w_reg_ok) begin
            w_wr_reg  = 1'b1;
            w_reg_sel = REG_ACC;
          end
        end
        4'hD: begin
          w_wr_acc  = 1'b1;
          w_acc_sel = ACC_IMM;
        end
        4'hF: begin
          case (r_opa)
            4'h0: begin
              w_clr_acc = 1'b1;
              w_clr_cy  = 1'b1;
            end
            4'h1: w_clr_cy = 1'b1;
            4'h2: begin
              w_wr_acc  = 1'b1;
              w_wr_cy   = 1'b1;
              w_acc_sel = ACC_ALU;
              w_alu_op  = ALU_ADD;
              w_in0_sel = IN0_ACC;
              w_in1_sel = IN1_ZERO;
              w_cin_sel = CIN_ONE;
            end
            4'h7: begin
              w_wr_acc  = 1'b1;
              w_acc_sel = ACC_CY;
              w_clr_cy  = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_phase       <= PH_A1;
      r_pc          <= RESET_VECTOR;
      r_opr         <= '0;
      r_opa         <= '0;
      r_cond        <= '0;
      r_addr_hi     <= '0;
      r_addr_lo     <= '0;
      r_second_word <= 1'b0;
      r_bus_out     <= '0;
      r_bus_oe      <= 1'b0;
      r_sync        <= 1'b0;
      r_clr_cy      <= 1'b0;
      r_wr_cy       <= 1'b0;
      r_clr_acc     <= 1'b0;
      r_wr_acc      <= 1'b0;
      r_wr_reg      <= 1'b0;
      r_acc_sel     <= '0;
      r_reg_sel     <= '0;
      r_alu_op      <= '0;
      r_in0_sel     <= '0;
      r_in1_sel     <= '0;
      r_cin_sel     <= '0;
    end else begin
      r_phase <= w_phase_next;
      r_pc    <= w_pc_next;

      if (!halt_req) begin
        case (r_phase)
          PH_M1: if (r_second_word) r_addr_hi <= bus_in; else r_opr <= bus_in;
          PH_M2: if (r_second_word) r_addr_lo <= bus_in; else r_opa <= bus_in;
          PH_X3: begin
            if (r_second_word) begin
              r_second_word <= 1'b0;
            end else if (r_opr == 4'h1 || r_opr == 4'h4) begin
              r_second_word <= 1'b1;
              if (r_opr == 4'h1) r_cond <= r_opa;
            end
          end
          default: ;
        endcase
      end

      // Outputs follow the next phase; under halt the next state equals the
      // current one, so these simply hold.
      r_bus_oe <= (w_phase_next == PH_A1) || (w_phase_next == PH_A2) ||
                  (w_phase_next == PH_A3);
      case (w_phase_next)
        PH_A1:   r_bus_out <= w_pc_next[3:0];
        PH_A2:   r_bus_out <= w_pc_next[7:4];
        PH_A3:   r_bus_out <= w_pc_next[11:8];
        default: r_bus_out <= '0;
      endcase
      r_sync <= (w_phase_next == PH_X3);
      if (w_phase_next == PH_X3) begin
        r_clr_cy  <= w_clr_cy;
        r_wr_cy   <= w_wr_cy;
        r_clr_acc <= w_clr_acc;
        r_wr_acc  <= w_wr_acc;
        r_wr_reg  <= w_wr_reg;
        r_acc_sel <= w_acc_sel;
        r_reg_sel <= w_reg_sel;
        r_alu_op  <= w_alu_op;
        r_in0_sel <= w_in0_sel;
        r_in1_sel <= w_in1_sel;
        r_cin_sel <= w_cin_sel;
      end else begin
        r_clr_cy  <= 1'b0;
        r_wr_cy   <= 1'b0;
        r_clr_acc <= 1'b0;
        r_wr_acc  <= 1'b0;
        r_wr_reg  <= 1'b0;
        r_acc_sel <= '0;
        r_reg_sel <= '0;
        r_alu_op  <= '0;
        r_in0_sel <= '0;
        r_in1_sel <= '0;
        r_cin_sel <= '0;
      end
    end
  end

  // halt_req must kill strobes immediately, including an X3 already entered.
  assign w_run = ~halt_req;

  assign halt              = halt_req;
  assign bus_out           = r_bus_out;
  assign bus_oe            = r_bus_oe;
  assign sync              = r_sync;
  assign inst_operand      = r_second_word ? r_cond : r_opa;
  assign clear_carry       = r_clr_cy  & w_run;
  assign write_carry       = r_wr_cy   & w_run;
  assign clear_accumulator = r_clr_acc & w_run;
  assign write_accumulator = r_wr_acc  & w_run;
  assign write_register    = r_wr_reg  & w_run;
  assign acc_input_sel     = r_acc_sel & {3{w_run}};
  assign reg_input_sel     = r_reg_sel & {2{w_run}};
  assign alu_op            = r_alu_op  & {2{w_run}};
  assign alu_in0_sel       = r_in0_sel & {3{w_run}};
  assign alu_in1_sel       = r_in1_sel & {2{w_run}};
  assign alu_cin_sel       = r_cin_sel & {2{w_run}};

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       halt_req;
  logic [3:0] bus_in;
  logic [3:0] bus_out;
  logic       bus_oe, sync, take_branch, halt;
  logic [3:0] inst_operand;
  logic       clear_carry, write_carry, clear_accumulator, write_accumulator, write_register;
  logic [2:0] acc_input_sel, alu_in0_sel;
  logic [1:0] reg_input_sel, alu_op, alu_in1_sel, alu_cin_sel;

  int n_tests = 0;
  int n_fail  = 0;

  control_sequencer #(.PC_WIDTH(12), .RESET_VECTOR(12'h000)) dut (
    .clock(clock), .reset(reset), .halt_req(halt_req), .bus_in(bus_in),
    .bus_out(bus_out), .bus_oe(bus_oe), .sync(sync), .take_branch(take_branch),
    .halt(halt), .inst_operand(inst_operand),
    .clear_carry(clear_carry), .write_carry(write_carry),
    .clear_accumulator(clear_accumulator), .write_accumulator(write_accumulator),
    .write_register(write_register), .acc_input_sel(acc_input_sel),
    .reg_input_sel(reg_input_sel), .alu_op(alu_op), .alu_in0_sel(alu_in0_sel),
    .alu_in1_sel(alu_in1_sel), .alu_cin_sel(alu_cin_sel)
  );

  always #5 clock = ~clock;

  logic [4:0]  w_strb;
  logic [13:0] w_sels;
  assign w_strb = {clear_carry, write_carry, clear_accumulator, write_accumulator, write_register};
  assign w_sels = {acc_input_sel, reg_input_sel, alu_op, alu_in0_sel, alu_in1_sel, alu_cin_sel};

  // Bench phase tracker, ROM and datapath model
  logic [2:0]  tb_ph;
  logic [7:0]  rom [0:4095];
  logic [11:0] cur_addr = '0;
  logic [3:0]  m_acc;
  logic        m_carry;
  logic [3:0]  m_reg [0:15];
  logic [3:0]  last_opnd;

  always @(posedge clock or negedge reset) begin
    if (!reset) tb_ph <= 3'd0;
    else if (!halt_req) tb_ph <= tb_ph + 3'd1;
  end

  always_comb begin
    bus_in = 4'h0;
    if (tb_ph == 3'd3) bus_in = rom[cur_addr][7:4];
    else if (tb_ph == 3'd4) bus_in = rom[cur_addr][3:0];
  end

  // Condition nibble: bit2 = acc zero, bit1 = carry, bit3 inverts.
  assign take_branch = inst_operand[3] ^
                       ((inst_operand[2] & (m_acc == 4'h0)) | (inst_operand[1] & m_carry));

  always @(negedge clock) begin
    logic [3:0] in0, in1, new_acc;
    logic       cin;
    logic [4:0] sum;
    if (reset) begin
      in0 = (alu_in0_sel == 3'd1) ? m_acc : (alu_in0_sel == 3'd2) ? m_reg[inst_operand] : 4'h0;
      in1 = (alu_in1_sel == 2'd1) ? m_reg[inst_operand] : 4'h0;
      if (alu_op == 2'd1) in1 = ~in1;
      case (alu_cin_sel)
        2'd1:    cin = 1'b1;
        2'd2:    cin = m_carry;
        2'd3:    cin = ~m_carry;
        default: cin = 1'b0;
      endcase
      sum = {1'b0, in0} + {1'b0, in1} + {4'b0, cin};
      new_acc = m_acc;
      if (clear_accumulator) new_acc = 4'h0;
      else if (write_accumulator) begin
        case (acc_input_sel)
          3'd0:    new_acc = sum[3:0];
          3'd1:    new_acc = m_reg[inst_operand];
          3'd2:    new_acc = inst_operand;
          3'd3:    new_acc = {3'b000, m_carry};
          default: new_acc = 4'hx;
        endcase
      end
      if (write_register) m_reg[inst_operand] = (reg_input_sel == 2'd1) ? m_acc : sum[3:0];
      if (clear_carry) m_carry = 1'b0;
      else if (write_carry) m_carry = sum[4];
      m_acc = new_acc;
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_bus"}, {11'd0, bus_oe, bus_out}, 16'h0);
    check({tag, "_sync"}, {15'd0, sync}, 16'h0);
    check({tag, "_strb"}, {11'd0, w_strb}, 16'h0);
    check({tag, "_sels"}, {2'd0, w_sels}, 16'h0);
    check({tag, "_opnd"}, {12'd0, inst_operand}, 16'h0);
  endtask

  // One machine cycle, entered just after the negedge inside A1.
  task automatic run_cycle(input bit after_rst, input int hold, output logic [11:0] addr);
    addr = '0;
    for (int i = 0; i < 8; i++) begin
      check("sync", {15'd0, sync}, {15'd0, (i == 7)});
      if (i != 7) check("strobe_idle", {11'd0, w_strb}, 16'h0);
      check("bus_oe", {15'd0, bus_oe}, {15'd0, ((i < 3) && !(after_rst && i == 0))});
      case (i)
        0: addr[3:0]  = bus_out;
        1: addr[7:4]  = bus_out;
        2: begin
          addr[11:8] = bus_out;
          cur_addr   = addr;
        end
        7: last_opnd = inst_operand;
        default: ;
      endcase
      if (i == 3 && hold > 0) begin
        halt_req = 1'b1;
        for (int k = 0; k < hold; k++) begin
          @(negedge clock); #1;
          check("halt_out", {15'd0, halt}, 16'h1);
          check("halt_strb", {11'd0, w_strb}, 16'h0);
          check("halt_sync", {15'd0, sync}, 16'h0);
          check("halt_oe", {15'd0, bus_oe}, 16'h0);
        end
        halt_req = 1'b0;
      end
      @(negedge clock); #1;
    end
  endtask

  logic [11:0] exp_addr [0:28] = '{
    12'h000, 12'h001, 12'h002, 12'h003, 12'h004, 12'h005, 12'h006, 12'h007,
    12'h008, 12'h009, 12'h00A, 12'h00B, 12'h00C, 12'h00D, 12'h00E, 12'h00F,
    12'h010, 12'h011, 12'h03A, 12'h03B, 12'h03C, 12'h010, 12'h011, 12'h012,
    12'h013, 12'h789, 12'h78A, 12'hFFF, 12'h000};

  initial begin
    logic [11:0] a;
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    for (int i = 0; i < 16; i++) m_reg[i] = 4'h0;
    m_reg[2] = 4'h3;
    m_reg[7] = 4'h9;
    m_acc = 4'h0;
    m_carry = 1'b0;
    last_opnd = 4'h0;
    rom[12'h000] = 8'hD5; rom[12'h001] = 8'h82; rom[12'h002] = 8'h92;
    rom[12'h003] = 8'hDF; rom[12'h004] = 8'hF2; rom[12'h005] = 8'hF7;
    rom[12'h006] = 8'h62; rom[12'h007] = 8'hB2; rom[12'h008] = 8'h67;
    rom[12'h009] = 8'hF0;
    rom[12'h010] = 8'h14; rom[12'h011] = 8'h3A;
    rom[12'h03A] = 8'hD2; rom[12'h03B] = 8'h40; rom[12'h03C] = 8'h10;
    rom[12'h012] = 8'h47; rom[12'h013] = 8'h89;
    rom[12'h789] = 8'h4F; rom[12'h78A] = 8'hFF;

    reset = 1'b0;
    halt_req = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check_reset_outs("rst0");
    reset = 1'b1;

    // Abandon the first cycle in M2 with a second reset.
    repeat (4) begin
      @(negedge clock); #1;
    end
    check("pre_m2_oe", {15'd0, bus_oe}, 16'h0);
    reset = 1'b0;
    #1;
    check_reset_outs("rst_m2");
    @(negedge clock); #1;
    check_reset_outs("rst_m2_hold");
    reset = 1'b1;

    for (int c = 0; c < 29; c++) begin
      run_cycle(c == 0, (c == 28) ? 5 : 0, a);
      check($sformatf("fetch_addr_%0d", c), {4'd0, a}, {4'd0, exp_addr[c]});
      case (c)
        0:  check("ldm5_acc", {12'd0, m_acc}, 16'h5);
        1:  begin
          check("add_acc", {12'd0, m_acc}, 16'h8);
          check("add_cy", {15'd0, m_carry}, 16'h0);
        end
        2:  begin
          check("sub_acc", {12'd0, m_acc}, 16'h5);
          check("sub_cy", {15'd0, m_carry}, 16'h1);
        end
        3:  check("ldmF_acc", {12'd0, m_acc}, 16'hF);
        4:  begin
          check("iac_acc", {12'd0, m_acc}, 16'h0);
          check("iac_cy", {15'd0, m_carry}, 16'h1);
        end
        5:  begin
          check("tcc_acc", {12'd0, m_acc}, 16'h1);
          check("tcc_cy", {15'd0, m_carry}, 16'h0);
        end
        6:  begin
          check("inc_r2", {12'd0, m_reg[2]}, 16'h4);
          check("inc_cy", {15'd0, m_carry}, 16'h0);
        end
        7:  begin
          check("xch_acc", {12'd0, m_acc}, 16'h4);
          check("xch_r2", {12'd0, m_reg[2]}, 16'h1);
        end
        8:  check("inc_r7_blocked", {12'd0, m_reg[7]}, 16'h9);
        9:  begin
          check("clb_acc", {12'd0, m_acc}, 16'h0);
          check("clb_cy", {15'd0, m_carry}, 16'h0);
        end
        17: check("jcn_opnd_taken", {12'd0, last_opnd}, 16'h4);
        18: check("ldm2_acc", {12'd0, m_acc}, 16'h2);
        22: check("jcn_opnd_not", {12'd0, last_opnd}, 16'h4);
        28: check("resume_acc", {12'd0, m_acc}, 16'h5);
        default: ;
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
